// File: rtl/board_link.sv
`default_nettype none
// ============================================================================
// Module   : board_link
// Purpose  : Full-duplex 8N1 serial link carrying a packed board state.
//            Frame = SYNC_BYTE, payload bytes (LSB byte first), optional XOR
//            check byte (present when BOARD_LINK_CHECKSUM_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module board_link #(
    parameter int         BOARD_W   = 162,
    parameter int         BAUD_DIV  = 868,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               trigger_in,
    input  logic [BOARD_W-1:0] val_in,
    output logic               tx_busy,
    output logic               tx_out,
    input  logic               rx_in,
    output logic [BOARD_W-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_err
);

    localparam int c_nbytes = (BOARD_W + 7) / 8;
    localparam int c_pad_w  = c_nbytes * 8;
`ifdef BOARD_LINK_CHECKSUM_EN
    localparam int c_nframe = c_nbytes + 2;
`else
    localparam int c_nframe = c_nbytes + 1;
`endif
    localparam int c_cnt_w  = $clog2(BAUD_DIV);
    localparam int c_idx_w  = $clog2(c_nframe + 1);

    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(BAUD_DIV / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(c_nframe - 1);
    localparam logic [c_idx_w-1:0] c_idx_nb    = c_idx_w'(c_nbytes);

    // ------------------------------------------------------------------ TX
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t            r_tx_state;
    logic [c_cnt_w-1:0]   r_tx_cnt;
    logic [2:0]           r_tx_bit;
    logic [c_idx_w-1:0]   r_tx_idx;
    logic [c_pad_w-1:0]   r_tx_shadow;
    logic [7:0]           r_tx_sh;
    logic [7:0]           w_tx_byte;
    logic [c_pad_w-1:0]   w_val_pad;
    logic                 w_tx_baud_end;
`ifdef BOARD_LINK_CHECKSUM_EN
    logic [7:0]           r_tx_chk;
`endif

    assign w_val_pad     = c_pad_w'(val_in);
    assign w_tx_baud_end = (r_tx_cnt == c_baud_last);

    // Payload is consumed by shifting the shadow down, so byte N is always [7:0].
    always_comb begin
        w_tx_byte = r_tx_shadow[7:0];
        if (r_tx_idx == '0) begin
            w_tx_byte = SYNC_BYTE;
        end
`ifdef BOARD_LINK_CHECKSUM_EN
        else if (r_tx_idx > c_idx_nb) begin
            w_tx_byte = r_tx_chk;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_idx    <= '0;
            r_tx_shadow <= '0;
            r_tx_sh     <= '0;
            tx_out      <= 1'b1;
            tx_busy     <= 1'b0;
`ifdef BOARD_LINK_CHECKSUM_EN
            r_tx_chk    <= '0;
`endif
        end else begin
            r_tx_cnt <= w_tx_baud_end ? '0 : r_tx_cnt + c_cnt_one;
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                    tx_out   <= 1'b1;
                    tx_busy  <= 1'b0;
                    if (trigger_in) begin
                        r_tx_shadow <= w_val_pad;
                        r_tx_idx    <= '0;
                        r_tx_state  <= TX_START;
                        tx_out      <= 1'b0;
                        tx_busy     <= 1'b1;
`ifdef BOARD_LINK_CHECKSUM_EN
                        r_tx_chk    <= '0;
`endif
                    end
                end
                TX_START: begin
                    if (w_tx_baud_end) begin
                        r_tx_sh    <= w_tx_byte;
                        tx_out     <= w_tx_byte[0];
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                        if (r_tx_idx != '0 && r_tx_idx <= c_idx_nb) begin
                            r_tx_shadow <= r_tx_shadow >> 8;
`ifdef BOARD_LINK_CHECKSUM_EN
                            r_tx_chk    <= r_tx_chk ^ r_tx_shadow[7:0];
`endif
                        end
                    end
                end
                TX_DATA: begin
                    if (w_tx_baud_end) begin
                        if (r_tx_bit == 3'd7) begin
                            tx_out     <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                            r_tx_sh  <= r_tx_sh >> 1;
                            tx_out   <= r_tx_sh[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tx_baud_end) begin
                        if (r_tx_idx == c_idx_last) begin
                            r_tx_state <= TX_IDLE;
                            tx_busy    <= 1'b0;
                        end else begin
                            r_tx_idx   <= r_tx_idx + c_idx_one;
                            r_tx_state <= TX_START;
                            tx_out     <= 1'b0;
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ RX
    typedef enum logic [1:0] {RX_HUNT, RX_START_CHK, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t            r_rx_state;
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_rx_prev;
    logic [c_cnt_w-1:0]   r_rx_cnt;
    logic [2:0]           r_rx_bit;
    logic [c_idx_w-1:0]   r_rx_idx;
    logic [7:0]           r_rx_sh;
    logic [c_pad_w-1:0]   r_rx_shadow;
    logic [c_pad_w-1:0]   w_rx_shadow_next;
`ifdef BOARD_LINK_CHECKSUM_EN
    logic [7:0]           r_rx_chk;
`endif

    assign w_rx_shadow_next = {r_rx_sh, r_rx_shadow[c_pad_w-1:8]};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rx_state  <= RX_HUNT;
            r_rx_meta   <= 1'b1;
            r_rx_sync   <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_idx    <= '0;
            r_rx_sh     <= '0;
            r_rx_shadow <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
`ifdef BOARD_LINK_CHECKSUM_EN
            r_rx_chk    <= '0;
`endif
        end else begin
            r_rx_meta <= rx_in;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            r_rx_cnt  <= r_rx_cnt + c_cnt_one;
            case (r_rx_state)
                RX_HUNT: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START_CHK;
                    end
                end
                RX_START_CHK: begin
                    // A start bit that is gone by mid-bit is line noise, not an error.
                    if (r_rx_cnt == c_half_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync ? RX_HUNT : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == c_baud_last) begin
                        r_rx_cnt <= '0;
                        r_rx_sh  <= {r_rx_sync, r_rx_sh[7:1]};
                        r_rx_bit <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == c_baud_last) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_HUNT;
                        if (!r_rx_sync) begin
                            rx_err   <= 1'b1;
                            r_rx_idx <= '0;
                        end else if (r_rx_idx == '0) begin
                            if (r_rx_sh == SYNC_BYTE) begin
                                r_rx_idx <= c_idx_one;
                            end
`ifdef BOARD_LINK_CHECKSUM_EN
                            r_rx_chk <= '0;
                        end else if (r_rx_idx <= c_idx_nb) begin
                            r_rx_shadow <= w_rx_shadow_next;
                            r_rx_chk    <= r_rx_chk ^ r_rx_sh;
                            r_rx_idx    <= r_rx_idx + c_idx_one;
                        end else begin
                            r_rx_idx <= '0;
                            if (r_rx_sh == r_rx_chk) begin
                                rx_data  <= r_rx_shadow[BOARD_W-1:0];
                                rx_valid <= 1'b1;
                            end else begin
                                rx_err <= 1'b1;
                            end
                        end
`else
                        end else begin
                            r_rx_shadow <= w_rx_shadow_next;
                            r_rx_idx    <= r_rx_idx + c_idx_one;
                            if (r_rx_idx == c_idx_nb) begin
                                r_rx_idx <= '0;
                                rx_data  <= w_rx_shadow_next[BOARD_W-1:0];
                                rx_valid <= 1'b1;
                            end
                        end
`endif
                    end
                end
                default: r_rx_state <= RX_HUNT;
            endcase
        end
    end

endmodule
`default_nettype wire
